// File: rtl/mod_reduce_if.sv
`default_nettype none
// ============================================================================
// Module   : mod_reduce_if
// Brief    : Valid/ready input and output channels of the modular reducer.
// Revision : 1.0
// ============================================================================
interface mod_reduce_if #(
    parameter int BITWIDTH = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2*BITWIDTH-1:0]   product;
    logic [BITWIDTH-1:0]     modulus;
    logic                    dbl;
    logic                    out_valid;
    logic                    out_ready;
    logic [BITWIDTH-1:0]     remainder;
    logic                    err_zero_mod;

    modport master (
        output in_valid, product, modulus, dbl, out_ready,
        input  in_ready, out_valid, remainder, err_zero_mod
    );

    modport slave (
        input  in_valid, product, modulus, dbl, out_ready,
        output in_ready, out_valid, remainder, err_zero_mod
    );
endinterface
`default_nettype wire

// File: rtl/mod_reduce.sv
`default_nettype none
// ============================================================================
// Module   : mod_reduce
// Brief    : Bit-serial restoring reducer, (product * (dbl ? 2 : 1)) mod q.
// Revision : 1.0
// ============================================================================
module mod_reduce #(
    parameter int BITWIDTH = 32
) (
    input  wire logic       sys_clk,
    input  wire logic       sys_rst,
    mod_reduce_if.slave     bus
);
    localparam int SW = 2*BITWIDTH + 1;
    localparam int CW = $clog2(SW + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(SW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         s_q, s_d;
    logic [BITWIDTH-1:0]   q_q, q_d;
    logic [BITWIDTH:0]     r_q, r_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BITWIDTH-1:0]   rem_q, rem_d;
    logic                  err_q, err_d;

    logic [BITWIDTH:0]     t_w;
    logic [BITWIDTH:0]     diff_w;
    logic [BITWIDTH:0]     r_next_w;
    logic                  ge_w;

    // r < q keeps t < 2q, so one conditional subtract restores the invariant
    assign t_w      = {r_q[BITWIDTH-1:0], s_q[SW-1]};
    assign diff_w   = t_w - {1'b0, q_q};
    assign ge_w     = (t_w >= {1'b0, q_q});
    assign r_next_w = ge_w ? diff_w : t_w;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    s_d     = bus.dbl ? {bus.product, 1'b0} : {1'b0, bus.product};
                    q_d     = bus.modulus;
                    r_d     = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (q_q == '0) begin
                    rem_d   = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    r_d   = r_next_w;
                    s_d   = {s_q[SW-2:0], 1'b0};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        rem_d   = r_next_w[BITWIDTH-1:0];
                        err_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // Ready is masked by reset so nothing can appear accepted on a reset edge
    assign bus.in_ready     = (state_q == IDLE) && !sys_rst;
    assign bus.out_valid    = (state_q == DONE);
    assign bus.remainder    = rem_q;
    assign bus.err_zero_mod = err_q;
endmodule
`default_nettype wire

// File: doc/mod_reduce.md
# mod_reduce

Sequential modular reducer directly downstream of the squarer in the Mersenne trial-factoring datapath. It accepts a 2·BITWIDTH-bit square and an optional doubling request, and returns (square · (dbl ? 2 : 1)) mod q as a BITWIDTH-bit remainder. Together with the squarer it forms one square-and-multiply step of 2^p mod q. It uses bit-serial restoring reduction with a valid/ready handshake on both sides.

## Interface

- BITWIDTH, 32, width of modulus and remainder; product is 2·BITWIDTH bits
- sys_clk  input  1  system clock; all logic on rising edge
- sys_rst  input  1  reset; synchronous, active-high
- in_valid  input  1  product/modulus/dbl valid
- in_ready  output  1  block can accept (high only in IDLE)
- product  input  2·BITWIDTH  square from the squarer
- modulus  input  BITWIDTH  candidate factor q
- dbl  input  1  reduce 2·product instead of product
- out_valid  output  1  remainder valid
- out_ready  input  1  consumer takes remainder
- remainder  output  BITWIDTH  result, always < q when err_zero_mod=0
- err_zero_mod  output  1  q was zero; remainder forced 0

## Operation

- Reset: one clock, one reset. Reset is synchronous and active-high: sys_clk and sys_rst, with sys_rst sampled on the rising edge of sys_clk.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. A handshake (in_valid & in_ready at an edge) latches the following:
  - shift register S (2·BITWIDTH+1 bits) = dbl ? {product,1'b0} : {1'b0,product}
  - q = modulus
  - partial remainder r (BITWIDTH+1 bits) = 0
  - iteration counter = 0
- If the latched modulus is 0: go to DONE with remainder=0 and err_zero_mod=1. No RUN cycles.
- Otherwise go to RUN with err_zero_mod=0.
- RUN: each edge performs one iteration, MSB of S first:
  - t = {r[BITWIDTH-1:0], S[MSB]}
  - r = (t ≥ q) ? t − q : t
  - S shifts left by 1
- Invariant: r < q after every iteration, so t < 2q fits in BITWIDTH+1 bits and one subtract suffices.
- After exactly 2·BITWIDTH+1 iterations: go to DONE with remainder = r[BITWIDTH-1:0].
- DONE: out_valid=1. remainder and err_zero_mod are held stable until out_valid & out_ready at an edge, then go to IDLE.
- in_ready=0 in RUN and DONE. Inputs are ignored outside IDLE.
- q=1 yields remainder 0 with no special case. A q with its MSB set is handled by the BITWIDTH+1-bit compare.
- Out-of-range inputs do not exist: any product and dbl are legal.

## Timing

- Reset values: in_ready=0 while sys_rst is high, then 1 from the first cycle after release (IDLE). out_valid=0, remainder=0, err_zero_mod=0.
- Latency, normal case: accept at edge E gives out_valid high after edge E+2·BITWIDTH+1 (65 edges at BITWIDTH=32).
- Latency, zero modulus: out_valid high after edge E+1.
- Release: an output handshake at edge F gives in_ready high after F. The next accept is at F+1 at the earliest.
- Throughput: one result per 2·BITWIDTH+3 cycles with no stalls.
- out_valid, once high, does not drop and remainder does not change until the handshake. There is no cap on backpressure duration.
- sys_rst high during any state: the next edge returns to IDLE with all outputs at reset values. The in-flight operation is discarded with no partial output.
- sys_rst and in_valid high on the same edge: reset wins and nothing is latched.

## Test plan

- product=100, q=7, dbl=0 -> remainder=2, err=0, out_valid 65 cycles after accept.
- product=100, q=7, dbl=1 -> remainder=4 (200 mod 7).
- product=0x0000_0001_0000_0000, q=0x8000_0001, dbl=0 -> remainder=0x7FFF_FFFF. Then the same product with q=0xFFFF_FFFF, dbl=1 -> remainder=2.
- product=0xFFFF_FFFF_FFFF_FFFF, q=0xFFFF_FFFF, dbl=1 -> remainder=0. Then q=0 -> err_zero_mod=1, remainder=0, out_valid 1 cycle after accept. Then q=1 -> remainder=0, err=0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> remainder/out_valid stable and in_ready=0 throughout. After the handshake, in_ready=1 the next cycle, and a back-to-back second operation returns the correct result.
- Assert sys_rst for one cycle at iteration 30 of a run -> outputs at reset values. A new operation (product=100, q=7) then completes correctly with remainder=2.
